tmds_channel_encoder: RTL and testbench

Registered, multi-channel TMDS encoder for the HDMI transmit path. It takes per-channel pixel, control and auxiliary nibbles plus a period mode, and produces one 10-bit TMDS symbol per channel per valid beat. Each channel keeps its own running-disparity register. The block sits between the video timing/packetiser stage and the 10:1 serialisers. It supersedes the combinational single-channel video encoder by adding channel parametrisation, internal disparity state, pipelining, and control, guard-band and TERC4 periods.

---
 rtl/tmds_channel_encoder_if.sv | 27 ++
 rtl/tmds_channel_encoder.sv | 227 ++++++++++++++++++++++
 tb/tb_tmds_channel_encoder.sv | 137 +++++++++++++
 3 files changed

// File: rtl/tmds_channel_encoder_if.sv
`default_nettype none
// ============================================================================
// tmds_channel_encoder_if : beat-in / symbol-out bus of the TMDS channel encoder
// Rev 1.0 - initial release
// ============================================================================
interface tmds_channel_encoder_if #(
  parameter int NUM_CH = 3
);
  logic                  i_valid;
  logic [1:0]            i_mode;
  logic [8*NUM_CH-1:0]   i_pixel_data;
  logic [2*NUM_CH-1:0]   i_ctrl;
  logic [4*NUM_CH-1:0]   i_aux;
  logic [10*NUM_CH-1:0]  o_encoded_data;
  logic                  o_valid;

  modport master (
    output i_valid, i_mode, i_pixel_data, i_ctrl, i_aux,
    input  o_encoded_data, o_valid
  );

  modport slave (
    input  i_valid, i_mode, i_pixel_data, i_ctrl, i_aux,
    output o_encoded_data, o_valid
  );
endinterface
`default_nettype wire

// File: rtl/tmds_channel_encoder.sv
`default_nettype none
// ============================================================================
// tmds_channel_encoder : registered multi-channel TMDS encoder (video, control,
// guard band, TERC4). Define TMDS_TERC4_EN to encode data islands from aux.
// Rev 1.0 - initial release
// ============================================================================
module tmds_channel_encoder #(
  parameter int NUM_CH = 3,
  parameter int CNT_W  = 5
) (
  input wire                    clk,
  input wire                    n_rst,
  tmds_channel_encoder_if.slave bus
);

  localparam logic [1:0] c_MODE_CTRL  = 2'b00;
  localparam logic [1:0] c_MODE_VIDEO = 2'b01;
  localparam logic [1:0] c_MODE_TERC4 = 2'b10;
  localparam logic [1:0] c_MODE_GUARD = 2'b11;

  localparam logic signed [CNT_W-1:0] c_ZERO  = '0;
  localparam logic signed [CNT_W-1:0] c_TWO   = CNT_W'(2);
  localparam logic signed [CNT_W-1:0] c_EIGHT = CNT_W'(8);

  // Input capture register (edge N)
  logic                  r_in_valid;
  logic [1:0]            r_in_mode;
  logic [8*NUM_CH-1:0]   r_in_pixel;
  logic [2*NUM_CH-1:0]   r_in_ctrl;
  // Stage 1: q_m (edge N+1)
  logic                  r_s1_valid;
  logic [1:0]            r_s1_mode;
  logic [9*NUM_CH-1:0]   r_s1_qm;
  logic [2*NUM_CH-1:0]   r_s1_ctrl;
  // Stage 2: symbol and disparity (edge N+2)
  logic                  r_out_valid;
  logic [10*NUM_CH-1:0]  r_out;
  logic signed [CNT_W-1:0] r_cnt [NUM_CH];

  logic [9*NUM_CH-1:0]     w_qm_all;
  logic [10*NUM_CH-1:0]    w_sym_all;
  logic [CNT_W*NUM_CH-1:0] w_cnt_nxt_all;

`ifdef TMDS_TERC4_EN
  logic [4*NUM_CH-1:0]   r_in_aux;
  logic [4*NUM_CH-1:0]   r_s1_aux;
`else
  logic                  w_unused_aux;
  assign w_unused_aux = ^bus.i_aux;
`endif

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    localparam logic [9:0] c_GUARD_SYM = ((k % 3) == 1) ? 10'b0100110011 : 10'b1011001100;

    logic [7:0]              w_d;
    logic [3:0]              w_d_ones;
    logic                    w_use_xnor;
    logic [8:0]              w_qm;
    logic [8:0]              w_q;
    logic [3:0]              w_q_ones;
    logic signed [CNT_W-1:0] w_cnt;
    logic signed [CNT_W-1:0] w_n1;
    logic signed [CNT_W-1:0] w_n0;
    logic [9:0]              w_vsym;
    logic signed [CNT_W-1:0] w_vcnt;
    logic [9:0]              w_ctrl_sym;
    logic [9:0]              w_sym;
    logic signed [CNT_W-1:0] w_cnt_nxt;

    assign w_d = r_in_pixel[8*k +: 8];

    always_comb begin
      w_d_ones = 4'd0;
      for (int i = 0; i < 8; i++) begin
        w_d_ones = w_d_ones + {3'b000, w_d[i]};
      end
      w_use_xnor = (w_d_ones > 4'd4) || ((w_d_ones == 4'd4) && !w_d[0]);
      w_qm       = '0;
      w_qm[0]    = w_d[0];
      for (int i = 1; i < 8; i++) begin
        w_qm[i] = w_use_xnor ? ~(w_qm[i-1] ^ w_d[i]) : (w_qm[i-1] ^ w_d[i]);
      end
      w_qm[8] = ~w_use_xnor;
    end

    assign w_qm_all[9*k +: 9] = w_qm;

    assign w_q   = r_s1_qm[9*k +: 9];
    assign w_cnt = r_cnt[k];

    always_comb begin
      w_q_ones = 4'd0;
      for (int i = 0; i < 8; i++) begin
        w_q_ones = w_q_ones + {3'b000, w_q[i]};
      end
    end

    assign w_n1 = $signed({{(CNT_W-4){1'b0}}, w_q_ones});
    assign w_n0 = c_EIGHT - w_n1;

    // Disparity-balanced video symbol selection
    always_comb begin
      w_vsym = '0;
      w_vcnt = w_cnt;
      if ((w_cnt == c_ZERO) || (w_n1 == w_n0)) begin
        w_vsym = {~w_q[8], w_q[8], w_q[8] ? w_q[7:0] : ~w_q[7:0]};
        w_vcnt = w_q[8] ? (w_cnt + (w_n1 - w_n0)) : (w_cnt + (w_n0 - w_n1));
      end else if (((w_cnt > c_ZERO) && (w_n1 > w_n0)) ||
                   ((w_cnt < c_ZERO) && (w_n0 > w_n1))) begin
        w_vsym = {1'b1, w_q[8], ~w_q[7:0]};
        w_vcnt = w_cnt + (w_q[8] ? c_TWO : c_ZERO) + (w_n0 - w_n1);
      end else begin
        w_vsym = {1'b0, w_q[8], w_q[7:0]};
        w_vcnt = w_cnt + (w_n1 - w_n0) - (w_q[8] ? c_ZERO : c_TWO);
      end
    end

    always_comb begin
      w_ctrl_sym = 10'b1101010100;
      case (r_s1_ctrl[2*k +: 2])
        2'b00:   w_ctrl_sym = 10'b1101010100;
        2'b01:   w_ctrl_sym = 10'b0010101011;
        2'b10:   w_ctrl_sym = 10'b0101010100;
        default: w_ctrl_sym = 10'b1010101011;
      endcase
    end

`ifdef TMDS_TERC4_EN
    logic [9:0] w_terc_sym;
    always_comb begin
      w_terc_sym = 10'b1010011100;
      case (r_s1_aux[4*k +: 4])
        4'h0:    w_terc_sym = 10'b1010011100;
        4'h1:    w_terc_sym = 10'b1001100011;
        4'h2:    w_terc_sym = 10'b1011100100;
        4'h3:    w_terc_sym = 10'b1011100010;
        4'h4:    w_terc_sym = 10'b0101110001;
        4'h5:    w_terc_sym = 10'b0100011110;
        4'h6:    w_terc_sym = 10'b0110001110;
        4'h7:    w_terc_sym = 10'b0100111100;
        4'h8:    w_terc_sym = 10'b1011001100;
        4'h9:    w_terc_sym = 10'b0100111001;
        4'hA:    w_terc_sym = 10'b0110011100;
        4'hB:    w_terc_sym = 10'b1011000110;
        4'hC:    w_terc_sym = 10'b1010001110;
        4'hD:    w_terc_sym = 10'b1001110001;
        4'hE:    w_terc_sym = 10'b0101100011;
        default: w_terc_sym = 10'b1011000011;
      endcase
    end
`endif

    // Every non-video period restarts disparity from zero
    always_comb begin
      w_sym     = w_ctrl_sym;
      w_cnt_nxt = c_ZERO;
      case (r_s1_mode)
        c_MODE_VIDEO: begin
          w_sym     = w_vsym;
          w_cnt_nxt = w_vcnt;
        end
        c_MODE_GUARD: w_sym = c_GUARD_SYM;
`ifdef TMDS_TERC4_EN
        c_MODE_TERC4: w_sym = w_terc_sym;
`endif
        default: w_sym = w_ctrl_sym;
      endcase
    end

    assign w_sym_all[10*k +: 10]         = w_sym;
    assign w_cnt_nxt_all[CNT_W*k +: CNT_W] = w_cnt_nxt;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_in_valid  <= 1'b0;
      r_in_mode   <= c_MODE_CTRL;
      r_in_pixel  <= '0;
      r_in_ctrl   <= '0;
      r_s1_valid  <= 1'b0;
      r_s1_mode   <= c_MODE_CTRL;
      r_s1_qm     <= '0;
      r_s1_ctrl   <= '0;
      r_out_valid <= 1'b0;
      r_out       <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        r_cnt[k] <= c_ZERO;
      end
`ifdef TMDS_TERC4_EN
      r_in_aux    <= '0;
      r_s1_aux    <= '0;
`endif
    end else begin
      r_in_valid  <= bus.i_valid;
      r_s1_valid  <= r_in_valid;
      r_out_valid <= r_s1_valid;
      if (bus.i_valid) begin
        r_in_mode  <= bus.i_mode;
        r_in_pixel <= bus.i_pixel_data;
        r_in_ctrl  <= bus.i_ctrl;
`ifdef TMDS_TERC4_EN
        r_in_aux   <= bus.i_aux;
`endif
      end
      if (r_in_valid) begin
        r_s1_mode <= r_in_mode;
        r_s1_qm   <= w_qm_all;
        r_s1_ctrl <= r_in_ctrl;
`ifdef TMDS_TERC4_EN
        r_s1_aux  <= r_in_aux;
`endif
      end
      // Bubbles leave both the held symbol and the disparity untouched
      if (r_s1_valid) begin
        r_out <= w_sym_all;
        for (int k = 0; k < NUM_CH; k++) begin
          r_cnt[k] <= $signed(w_cnt_nxt_all[CNT_W*k +: CNT_W]);
        end
      end
    end
  end

  assign bus.o_encoded_data = r_out;
  assign bus.o_valid        = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_tmds_channel_encoder.sv
`default_nettype none
// ============================================================================
// tb_tmds_channel_encoder : directed-vector bench for tmds_channel_encoder
// Rev 1.0 - initial release
// ============================================================================
module tb_tmds_channel_encoder;
  localparam int NUM_CH = 3;

  localparam logic [1:0] c_CTRL  = 2'b00;
  localparam logic [1:0] c_VIDEO = 2'b01;
  localparam logic [1:0] c_TERC4 = 2'b10;
  localparam logic [1:0] c_GUARD = 2'b11;

  logic clk = 1'b0;
  logic n_rst;
  int   n_vec  = 0;
  int   n_miss = 0;

  always #5 clk = ~clk;

  tmds_channel_encoder_if #(.NUM_CH(NUM_CH)) bus ();

  tmds_channel_encoder #(
    .NUM_CH (NUM_CH),
    .CNT_W  (5)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] m, input logic [23:0] pix,
                       input logic [5:0] ctl, input logic [11:0] ax);
    bus.i_valid      = v;
    bus.i_mode       = m;
    bus.i_pixel_data = pix;
    bus.i_ctrl       = ctl;
    bus.i_aux        = ax;
  endtask

  task automatic one_beat(input string tag, input logic [1:0] m, input logic [23:0] pix,
                          input logic [5:0] ctl, input logic [11:0] ax,
                          input logic [29:0] exp_sym);
    drive(1'b1, m, pix, ctl, ax);
    step();
    drive(1'b0, m, pix, ctl, ax);
    step();
    check_eq({tag, "_lat"}, {31'd0, bus.o_valid}, 32'd0);
    step();
    check_eq({tag, "_vld"}, {31'd0, bus.o_valid}, 32'd1);
    check_eq(tag, {2'b00, bus.o_encoded_data}, {2'b00, exp_sym});
  endtask

  logic [29:0] exp_terc;

  initial begin
    n_rst = 1'b0;
    drive(1'b1, c_VIDEO, 24'hFFFFFF, 6'd0, 12'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("rst_data", {2'b00, bus.o_encoded_data}, 32'd0);
      check_eq("rst_vld", {31'd0, bus.o_valid}, 32'd0);
    end
    drive(1'b0, c_VIDEO, 24'h0, 6'd0, 12'd0);
    step();
    n_rst = 1'b1;
    step();

    one_beat("vid00_a", c_VIDEO, 24'h000000, 6'd0, 12'd0, {3{10'h100}});

    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("stall_vld", {31'd0, bus.o_valid}, 32'd0);
      check_eq("stall_hold", {2'b00, bus.o_encoded_data}, {2'b00, {3{10'h100}}});
    end
    one_beat("vid00_b", c_VIDEO, 24'h000000, 6'd0, 12'd0, {3{10'h3FF}});

    one_beat("ctrl", c_CTRL, 24'h0, 6'b111001, 12'd0, {10'h2AB, 10'h154, 10'h0AB});
    one_beat("vidFF", c_VIDEO, 24'hFFFFFF, 6'd0, 12'd0, {3{10'h200}});
    one_beat("guard", c_GUARD, 24'h0, 6'd0, 12'd0, {10'h2CC, 10'h133, 10'h2CC});
    one_beat("vid_after_guard", c_VIDEO, 24'h000000, 6'd0, 12'd0, {3{10'h100}});

`ifdef TMDS_TERC4_EN
    exp_terc = {10'h29C, 10'h29C, 10'h11E};
`else
    exp_terc = {3{10'h354}};
`endif
    one_beat("terc4", c_TERC4, 24'h0, 6'd0, 12'h005, exp_terc);

    drive(1'b1, c_VIDEO, 24'h000000, 6'd0, 12'd0);
    step();
    drive(1'b1, c_VIDEO, 24'h000000, 6'd0, 12'd0);
    step();
    drive(1'b1, c_CTRL, 24'h0, 6'b010101, 12'd0);
    step();
    drive(1'b0, c_CTRL, 24'h0, 6'd0, 12'd0);
    check_eq("b2b_a_vld", {31'd0, bus.o_valid}, 32'd1);
    check_eq("b2b_a", {2'b00, bus.o_encoded_data}, {2'b00, {3{10'h100}}});
    step();
    check_eq("b2b_b_vld", {31'd0, bus.o_valid}, 32'd1);
    check_eq("b2b_b", {2'b00, bus.o_encoded_data}, {2'b00, {3{10'h3FF}}});
    step();
    check_eq("b2b_c_vld", {31'd0, bus.o_valid}, 32'd1);
    check_eq("b2b_c", {2'b00, bus.o_encoded_data}, {2'b00, {3{10'h0AB}}});

    drive(1'b1, c_VIDEO, 24'h000000, 6'd0, 12'd0);
    step();
    drive(1'b0, c_VIDEO, 24'h000000, 6'd0, 12'd0);
    n_rst = 1'b0;
    #1;
    check_eq("midrst_data", {2'b00, bus.o_encoded_data}, 32'd0);
    check_eq("midrst_vld", {31'd0, bus.o_valid}, 32'd0);
    step();
    n_rst = 1'b1;
    step();
    step();
    check_eq("midrst_drop", {31'd0, bus.o_valid}, 32'd0);
    one_beat("vidFF_post_rst", c_VIDEO, 24'hFFFFFF, 6'd0, 12'd0, {3{10'h200}});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
`default_nettype wire
